md_sched: RTL and testbench

- Multi-cycle multiply/divide sequencer for the E stage. It owns the HI/LO register pair whose outputs feed the E-stage result mux (HIO/LOO).
- Accepts one mult/div/move-to-HI/LO operation at a time and counts out its latency. It then commits the result to HI/LO.
- Drives a stall request so the hazard unit holds D while the unit is busy and the D-stage instruction needs it.

---
 rtl/md_sched_if.sv | 23 ++
 rtl/md_sched.sv | 151 +++++++++++++++
 tb/tb_md_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// E-stage <-> multiply/divide sequencer bundle: op issue, operands, flush, D-stage use, HI/LO results.
interface md_sched_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        md_use_D;
  logic        busy;
  logic        md_stall;
  logic [31:0] HIO;
  logic [31:0] LOO;

  modport master (
    output start, md_op, A, B, cancel, md_use_D,
    input  busy, md_stall, HIO, LOO
  );

  modport slave (
    input  start, md_op, A, B, cancel, md_use_D,
    output busy, md_stall, HIO, LOO
  );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle mult/div sequencer owning HI/LO; busy for exactly N cycles, commit on the last edge.
// mthi/mtlo write in one edge from IDLE; cancel aborts without commit; md_stall holds D while the unit is needed.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_sched_if.slave md
);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        issue, commit, wr_hi, wr_lo;
  logic [31:0] res_hi, res_lo;

  // State register plus the HI/LO pair and latched operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (issue) begin
        op_q <= md.md_op;
        a_q  <= md.A;
        b_q  <= md.B;
      end
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else begin
        if (wr_hi) hi_q <= md.A;
        if (wr_lo) lo_q <= md.A;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    issue   = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (md.start && !md.cancel) begin
          case (md.md_op)
            OP_MULT, OP_MULTU: begin
              issue   = 1'b1;
              cnt_n   = MULT_LOAD;
              state_n = RUN;
            end
            OP_DIV, OP_DIVU: begin
              issue   = 1'b1;
              cnt_n   = DIV_LOAD;
              state_n = RUN;
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        // A flush on the final cycle still wins over the commit
        if (md.cancel) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else if (cnt == 4'd0) begin
          commit  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    md.busy = (state == RUN);
  end

  assign md.md_stall = ~reset & md.md_use_D & (md.busy | md.start);
  assign md.HIO = hi_q;
  assign md.LOO = lo_q;

  // Result datapath works on latched operands only; the register write happens at commit.
  logic [63:0] sprod, uprod;
  logic [31:0] mag_a, mag_b, smag_q, smag_r, uq, ur, sq, sr;

  assign sprod  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign uprod  = {32'd0, a_q} * {32'd0, b_q};
  assign mag_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign mag_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
  assign smag_q = mag_a / mag_b;
  assign smag_r = mag_a % mag_b;
  assign uq     = a_q / b_q;
  assign ur     = a_q % b_q;
  // 0x80000000 / -1 falls out of the magnitude path as 0x80000000 rem 0
  assign sq     = (a_q[31] ^ b_q[31]) ? (~smag_q + 32'd1) : smag_q;
  assign sr     = a_q[31] ? (~smag_r + 32'd1) : smag_r;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = sprod;
      OP_MULTU: {res_hi, res_lo} = uprod;
      OP_DIV: begin
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      OP_DIVU: begin
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: latency, HI/LO results, mthi/mtlo, cancel, stall and async reset.
module tb_md_sched;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n;
  int   stall_n;

  md_sched_if bus ();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns just after the issue edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
    bus.md_op = 3'b000;
  endtask

  // Count busy cycles until the unit goes idle, bounded
  task automatic count_busy(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.md_op    = 3'b001;
    bus.A        = 32'd0;
    bus.B        = 32'd0;
    bus.cancel   = 1'b0;
    bus.md_use_D = 1'b1;
    #12;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_stall", {31'd0, bus.md_stall}, 32'd0);
    check("rst_hi", bus.HIO, 32'd0);
    check("rst_lo", bus.LOO, 32'd0);
    bus.start    = 1'b0;
    bus.md_op    = 3'b000;
    bus.md_use_D = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();

    // mult -2 * 3
    issue(3'b001, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    check("mult_lat", n, 32'd5);
    check("mult_hi", bus.HIO, 32'hFFFF_FFFF);
    check("mult_lo", bus.LOO, 32'hFFFF_FFFA);

    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(n);
    check("multu_lat", n, 32'd5);
    check("multu_hi", bus.HIO, 32'hFFFF_FFFE);
    check("multu_lo", bus.LOO, 32'h0000_0001);

    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check("div_lat", n, 32'd10);
    check("div_neg_lo", bus.LOO, 32'hFFFF_FFFD);
    check("div_neg_hi", bus.HIO, 32'hFFFF_FFFF);

    issue(3'b011, 32'd7, 32'hFFFF_FFFE);
    count_busy(n);
    check("div_negb_lo", bus.LOO, 32'hFFFF_FFFD);
    check("div_negb_hi", bus.HIO, 32'd1);

    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    check("div_ovf_lat", n, 32'd10);
    check("div_ovf_lo", bus.LOO, 32'h8000_0000);
    check("div_ovf_hi", bus.HIO, 32'd0);

    issue(3'b100, 32'd7, 32'd2);
    count_busy(n);
    check("divu_lo", bus.LOO, 32'd3);
    check("divu_hi", bus.HIO, 32'd1);

    issue(3'b100, 32'd5, 32'd0);
    count_busy(n);
    check("divu0_lat", n, 32'd10);
    check("divu0_hi", bus.HIO, 32'd5);
    check("divu0_lo", bus.LOO, 32'hFFFF_FFFF);

    issue(3'b011, 32'hFFFF_FFF0, 32'd0);
    count_busy(n);
    check("div0_hi", bus.HIO, 32'hFFFF_FFF0);
    check("div0_lo", bus.LOO, 32'hFFFF_FFFF);

    // mthi then mtlo back to back, D stage using the unit
    bus.md_use_D = 1'b1;
    bus.start    = 1'b1;
    bus.md_op    = 3'b101;
    bus.A        = 32'h1234_5678;
    #1;
    check("mthi_stall", {31'd0, bus.md_stall}, 32'd1);
    tick();
    check("mthi_hi", bus.HIO, 32'h1234_5678);
    check("mthi_lo", bus.LOO, 32'hFFFF_FFFF);
    check("mthi_busy", {31'd0, bus.busy}, 32'd0);
    bus.md_op = 3'b110;
    bus.A     = 32'h9ABC_DEF0;
    tick();
    check("mtlo_lo", bus.LOO, 32'h9ABC_DEF0);
    check("mtlo_hi", bus.HIO, 32'h1234_5678);
    check("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    bus.md_op = 3'b000;
    #1;
    check("idle_stall", {31'd0, bus.md_stall}, 32'd0);
    bus.md_use_D = 1'b0;

    // cancel on the 4th busy cycle of a div
    issue(3'b101, 32'h1111_1111, 32'd0);
    issue(3'b110, 32'h1111_1111, 32'd0);
    issue(3'b011, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    check("cancel_pre_busy", {31'd0, bus.busy}, 32'd1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel_busy", {31'd0, bus.busy}, 32'd0);
    repeat (12) tick();
    check("cancel_hi", bus.HIO, 32'h1111_1111);
    check("cancel_lo", bus.LOO, 32'h1111_1111);

    // cancel on the final mult cycle
    issue(3'b001, 32'd2, 32'd3);
    repeat (4) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel_last_busy", {31'd0, bus.busy}, 32'd0);
    check("cancel_last_lo", bus.LOO, 32'h1111_1111);

    // start together with cancel in IDLE
    bus.cancel = 1'b1;
    issue(3'b101, 32'hDEAD_BEEF, 32'd0);
    check("sc_mthi_hi", bus.HIO, 32'h1111_1111);
    issue(3'b011, 32'd9, 32'd3);
    bus.cancel = 1'b0;
    check("sc_div_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("sc_div_lo", bus.LOO, 32'h1111_1111);

    // stall coverage with ignored re-issue mid-RUN
    bus.md_use_D = 1'b1;
    bus.start    = 1'b1;
    bus.md_op    = 3'b001;
    bus.A        = 32'd3;
    bus.B        = 32'd4;
    #1;
    check("issue_stall", {31'd0, bus.md_stall}, 32'd1);
    tick();
    bus.start = 1'b0;
    bus.md_op = 3'b000;
    n = 0;
    stall_n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      if (bus.md_stall === 1'b1) stall_n++;
      if (n == 2) begin
        bus.start = 1'b1;
        bus.md_op = 3'b001;
        bus.A     = 32'd100;
        bus.B     = 32'd100;
      end else begin
        bus.start = 1'b0;
        bus.md_op = 3'b000;
      end
      tick();
    end
    bus.start = 1'b0;
    bus.md_op = 3'b000;
    #1;
    check("reissue_lat", n, 32'd5);
    check("reissue_stall_cyc", stall_n, 32'd5);
    check("reissue_hi", bus.HIO, 32'd0);
    check("reissue_lo", bus.LOO, 32'd12);
    check("post_stall", {31'd0, bus.md_stall}, 32'd0);
    bus.md_use_D = 1'b0;

    // async reset mid-RUN
    issue(3'b101, 32'h5555_5555, 32'd0);
    issue(3'b010, 32'd6, 32'd7);
    tick();
    reset = 1'b1;
    #2;
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_hi", bus.HIO, 32'd0);
    check("mid_rst_lo", bus.LOO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) tick();
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("post_rst_lo", bus.LOO, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
